aco_frame_rx: RTL and testbench
===============================

# aco_frame_rx

Receive-side buffer for the acoustic featurisation stream. It accepts the framed output of the `aco` pipeline: 104-bit packed MFCC vectors with `valid`/`last`, 50 vectors per word frame. It checks frame length and stores complete frames in a two-bank ping-pong memory. The wake-word detector then reads the stored frames by random access and releases each bank when it is done.

## Interface
Parameters:
- `I_BW`, 104, width of one packed feature vector (13 coefficients × 8 bits)
- `FRAME_LEN`, 50, number of vectors per frame
- `ADDR_BW`, 6, read address width; must satisfy 2^ADDR_BW ≥ FRAME_LEN

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `en_i`  in  1  input enable; when low, input beats are ignored
- `data_i`  in  I_BW  feature vector
- `valid_i`  in  1  input beat strobe; there is no backpressure
- `last_i`  in  1  marks the final vector of a frame
- `frame_valid_o`  out  1  the current read bank holds a complete frame
- `rd_en_i`  in  1  read request
- `rd_addr_i`  in  ADDR_BW  vector index to read
- `rd_data_o`  out  I_BW  read data
- `rd_valid_o`  out  1  `rd_data_o` is valid this cycle
- `release_i`  in  1  consumer is finished with the current read bank
- `len_err_o`  out  1  one-cycle pulse: frame had the wrong length and was discarded
- `ovf_o`  out  1  one-cycle pulse: frame arrived with both banks full and was discarded

## Operation
- Storage: 2 banks × FRAME_LEN × I_BW.
- State: `full[1:0]`, `wr_bank`, `rd_bank`, `wr_idx` (0..FRAME_LEN-1), write FSM.
- The banks behave as a depth-2 FIFO. `wr_bank` toggles only when a frame completes; `rd_bank` toggles only on an accepted release.
- An accepted beat is a cycle with `en_i & valid_i`.
- Write FSM has two states, FILL and DROP; reset state is FILL with `wr_idx`=0.
- FILL, accepted beat with `wr_idx`==0 and `full[wr_bank]`==1:
  - pulse `ovf_o`;
  - go to DROP, or stay in FILL if `last_i`=1.
- FILL, otherwise, each accepted beat:
  - write `data_i` to `mem[wr_bank][wr_idx]`.
  - If `last_i` and `wr_idx`==FRAME_LEN-1: set `full[wr_bank]`, toggle `wr_bank`, clear `wr_idx`.
  - If `last_i` and `wr_idx`<FRAME_LEN-1 (short frame): pulse `len_err_o`, clear `wr_idx`; the bank stays empty.
  - If `!last_i` and `wr_idx`==FRAME_LEN-1 (long frame): pulse `len_err_o`, clear `wr_idx`, go to DROP.
  - Otherwise increment `wr_idx`.
- DROP: accepted beats are discarded with no writes and no further pulses. The beat carrying `last_i` returns the FSM to FILL with `wr_idx`=0.
- `frame_valid_o` = `full[rd_bank]`.
- Read:
  - On `rd_en_i`, `rd_data_o` returns `mem[rd_bank][rd_addr_i]` and `rd_valid_o`=1 on the next cycle.
  - If `frame_valid_o` was 0 or `rd_addr_i` ≥ FRAME_LEN, `rd_valid_o`=1 still fires and `rd_data_o`=0.
  - When `rd_en_i` is low, `rd_valid_o`=0 and `rd_data_o` holds its previous value.
- Release: `release_i & frame_valid_o` clears `full[rd_bank]` and toggles `rd_bank`. `release_i` with `frame_valid_o`=0 is ignored.
- Release and frame completion in the same cycle always target different banks; both updates apply.
- `en_i`=0 freezes the write side only. Reads and releases continue.
- Reset:
  - all of `full`, `wr_bank`, `rd_bank`, `wr_idx`, the FSM, and every output clear to 0;
  - a partially received or stored frame is lost;
  - memory contents are don't-care.

## Timing
- `frame_valid_o` rises 1 cycle after the accepted `last_i` beat that completes a frame.
- Read latency is 1 cycle. One read is accepted per cycle, fully pipelined.
- Release takes effect 1 cycle later:
  - if the other bank is empty, `frame_valid_o` drops;
  - if the other bank is full, `frame_valid_o` stays 1 and reads now address the other bank.
- A read issued in the same cycle as `release_i` returns data from the bank being released.
- `len_err_o` and `ovf_o` pulse high for exactly 1 cycle, in the cycle after the offending beat.
- Back-to-back frames with no gap between one `last_i` and the next first beat are accepted without loss.

## Test plan
- Send 50 beats with data = index, `last_i` on beat 49 → `frame_valid_o`=1 one cycle later; reading addresses 0..49 returns 0..49 with 1-cycle latency; `release_i` → `frame_valid_o`=0.
- Send three back-to-back frames with no release → frames 0 and 1 stored; `ovf_o` pulses after the first beat of frame 2; two releases read frame 0 then frame 1 in order.
- Send a 30-beat frame with `last_i` on beat 29 → `len_err_o` pulses once and `frame_valid_o` stays 0; a following 50-beat frame is stored correctly.
- Send a 60-beat frame with `last_i` on beat 59 → `len_err_o` pulses after beat 49 and beats 50..59 are dropped; the next valid frame lands in bank 0.
- Hold `en_i`=0 during beats 10..19 of a 60-beat stream → only 50 beats are accepted and the frame completes normally; assert `rst_i` mid-frame → all outputs 0 next cycle, `frame_valid_o`=0, and a subsequent frame is stored in bank 0.
- Assert `release_i` in the same cycle as frame completion with the other bank full → `frame_valid_o` stays 1, `rd_bank` toggles, and there is no `ovf_o`.

Source files
------------

// File: rtl/aco_frame_rx.sv
// Receive buffer for framed MFCC vectors: checks frame length and stores whole
// frames in a two-bank ping-pong memory that the consumer reads randomly and releases.
module aco_frame_rx #(
  parameter int I_BW      = 104,
  parameter int FRAME_LEN = 50,
  parameter int ADDR_BW   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [I_BW-1:0]    data_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic               frame_valid_o,
  input  logic               rd_en_i,
  input  logic [ADDR_BW-1:0] rd_addr_i,
  output logic [I_BW-1:0]    rd_data_o,
  output logic               rd_valid_o,
  input  logic               release_i,
  output logic               len_err_o,
  output logic               ovf_o
);

  typedef enum logic {FILL = 1'b0, DROP = 1'b1} st_t;

  typedef struct packed {
    logic wr;       // store data_i at mem[wr_bank][wr_idx]
    logic done;     // frame of exact length completed
    logic clr;      // reset wr_idx
    logic inc;      // advance wr_idx
    logic len_err;
    logic ovf;
  } wr_ctl_t;

  localparam logic [ADDR_BW-1:0] LAST_IDX = ADDR_BW'(FRAME_LEN - 1);

  logic [I_BW-1:0]    mem [2][FRAME_LEN];
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, rd_bank_q;
  logic [ADDR_BW-1:0] wr_idx_q;
  st_t                st_q, st_d;
  wr_ctl_t            ctl;
  logic               beat, rel, rd_ok, no_room;

  assign beat          = en_i & valid_i;
  assign frame_valid_o = full_q[rd_bank_q];
  assign rel           = release_i & frame_valid_o;
  assign rd_ok         = frame_valid_o && (int'(rd_addr_i) < FRAME_LEN);
  // Write bank still occupied at a frame start means both banks are full.
  assign no_room       = (wr_idx_q == '0) && full_q[wr_bank_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) st_q <= FILL;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (beat) begin
      case (st_q)
        FILL: begin
          if (no_room)                               st_d = last_i ? FILL : DROP;
          else if (!last_i && wr_idx_q == LAST_IDX)  st_d = DROP;
        end
        DROP:    if (last_i) st_d = FILL;
        default: st_d = FILL;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    if (beat && st_q == FILL) begin
      if (no_room) begin
        ctl.ovf = 1'b1;
      end else begin
        ctl.wr = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          ctl.clr     = 1'b1;
          ctl.done    = last_i;
          ctl.len_err = ~last_i;
        end else if (last_i) begin
          ctl.clr     = 1'b1;
          ctl.len_err = 1'b1;
        end else begin
          ctl.inc = 1'b1;
        end
      end
    end
  end

  // Completion and release never hit the same bank, so both apply.
  always_comb begin
    full_d = full_q;
    if (ctl.done) full_d[wr_bank_q] = 1'b1;
    if (rel)      full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (ctl.wr) mem[wr_bank_q][wr_idx_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      len_err_o  <= 1'b0;
      ovf_o      <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      full_q    <= full_d;
      len_err_o <= ctl.len_err;
      ovf_o     <= ctl.ovf;
      if (ctl.clr)      wr_idx_q <= '0;
      else if (ctl.inc) wr_idx_q <= wr_idx_q + 1'b1;
      if (ctl.done) wr_bank_q <= ~wr_bank_q;
      if (rel)      rd_bank_q <= ~rd_bank_q;
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_ok ? mem[rd_bank_q][rd_addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_aco_frame_rx.sv
// Directed bench for aco_frame_rx: frame storage, ping-pong order, length errors,
// overflow, enable gating, reset and release/complete collision.
module tb_aco_frame_rx;

  logic         clk = 1'b0;
  logic         rst, en, valid, last, rd_en, rel;
  logic [103:0] data;
  logic [5:0]   rd_addr;
  logic         frame_valid, rd_valid, len_err, ovf;
  logic [103:0] rd_data;

  int checks = 0, errors = 0;
  int len_cnt, ovf_cnt, len_at, ovf_at;

  always #5 clk = ~clk;

  aco_frame_rx dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(data), .valid_i(valid),
    .last_i(last), .frame_valid_o(frame_valid), .rd_en_i(rd_en),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .release_i(rel), .len_err_o(len_err), .ovf_o(ovf)
  );

  task automatic chk(input string tag, input logic [103:0] got, input logic [103:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] vec(input int tag, input int idx);
    return {8'(tag), 88'(0), 8'(idx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    len_cnt = 0; ovf_cnt = 0; len_at = -1; ovf_at = -1;
  endtask

  // One input beat; pulses land right after the edge that takes the beat.
  task automatic send_beat(input logic [103:0] d, input bit l, input int idx);
    valid = 1'b1; data = d; last = l;
    tick();
    valid = 1'b0; last = 1'b0;
    if (len_err) begin len_cnt++; len_at = idx; end
    if (ovf)     begin ovf_cnt++; ovf_at = idx; end
  endtask

  task automatic send_frame(input int tag, input int n);
    for (int i = 0; i < n; i++) send_beat(vec(tag, i), i == n - 1, i);
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [103:0] exp);
    rd_en = 1'b1; rd_addr = 6'(addr);
    tick();
    rd_en = 1'b0;
    chk({tag, "_v"}, rd_valid, 1'b1);
    chk(tag, rd_data, exp);
  endtask

  task automatic release_bank();
    rel = 1'b1;
    tick();
    rel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; last = 1'b0; data = '0;
    rd_en = 1'b0; rd_addr = '0; rel = 1'b0;
    clr_cnt();
    tick(); tick();
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_rdd", rd_data, '0);
    chk("rst_len", len_err, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    tick();

    // Single frame, data = index, full readback then release
    for (int i = 0; i < 49; i++) send_beat(vec(0, i), 1'b0, i);
    chk("f0_fv_early", frame_valid, 1'b0);
    send_beat(vec(0, 49), 1'b1, 49);
    chk("f0_fv", frame_valid, 1'b1);
    for (int i = 0; i < 50; i++) rd_chk($sformatf("f0_rd%0d", i), i, 104'(i));
    rd_chk("f0_oob", 55, '0);
    tick();
    chk("f0_idle_v", rd_valid, 1'b0);
    chk("f0_idle_hold", rd_data, '0);
    rd_chk("f0_rd7", 7, 104'(7));
    tick();
    chk("f0_hold", rd_data, 104'(7));
    release_bank();
    chk("f0_rel_fv", frame_valid, 1'b0);
    rd_chk("empty_rd", 3, '0);
    chk("f0_pulses", 104'(len_cnt + ovf_cnt), 0);

    // Three back-to-back frames, third overflows
    clr_cnt();
    send_frame(1, 50);
    send_frame(2, 50);
    send_frame(3, 50);
    chk("ovf_cnt", 104'(ovf_cnt), 1);
    chk("ovf_at", 104'(ovf_at), 0);
    chk("ovf_len", 104'(len_cnt), 0);
    chk("bb_fv", frame_valid, 1'b1);
    rd_chk("bb1_rd0", 0, vec(1, 0));
    rd_chk("bb1_rd49", 49, vec(1, 49));
    release_bank();
    chk("bb_fv_after1", frame_valid, 1'b1);
    rd_chk("bb2_rd0", 0, vec(2, 0));
    rd_chk("bb2_rd33", 33, vec(2, 33));
    release_bank();
    chk("bb_fv_after2", frame_valid, 1'b0);

    // Short frame then good frame
    clr_cnt();
    send_frame(4, 30);
    chk("short_len_cnt", 104'(len_cnt), 1);
    chk("short_len_at", 104'(len_at), 29);
    chk("short_fv", frame_valid, 1'b0);
    send_frame(5, 50);
    chk("short_next_fv", frame_valid, 1'b1);
    rd_chk("s5_rd0", 0, vec(5, 0));
    rd_chk("s5_rd29", 29, vec(5, 29));
    rd_chk("s5_rd49", 49, vec(5, 49));
    release_bank();

    // Long frame: error after beat 49, remainder dropped
    clr_cnt();
    send_frame(6, 60);
    chk("long_len_cnt", 104'(len_cnt), 1);
    chk("long_len_at", 104'(len_at), 49);
    chk("long_fv", frame_valid, 1'b0);
    send_frame(7, 50);
    chk("long_next_fv", frame_valid, 1'b1);
    rd_chk("l7_rd0", 0, vec(7, 0));
    rd_chk("l7_rd49", 49, vec(7, 49));
    chk("long_ovf", 104'(ovf_cnt), 0);
    release_bank();

    // en_i low on beats 10..19 of a 60-beat stream
    clr_cnt();
    for (int i = 0; i < 60; i++) begin
      en = !(i >= 10 && i < 20);
      send_beat(vec(8, i), i == 59, i);
    end
    en = 1'b1;
    chk("en_fv", frame_valid, 1'b1);
    chk("en_len", 104'(len_cnt), 0);
    rd_chk("en_rd9", 9, vec(8, 9));
    rd_chk("en_rd10", 10, vec(8, 20));
    rd_chk("en_rd49", 49, vec(8, 59));

    // Reset in the middle of a frame
    for (int i = 0; i < 20; i++) send_beat(vec(9, i), 1'b0, i);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_fv", frame_valid, 1'b0);
    chk("mrst_rdv", rd_valid, 1'b0);
    chk("mrst_rdd", rd_data, '0);
    chk("mrst_len", len_err, 1'b0);
    chk("mrst_ovf", ovf, 1'b0);
    clr_cnt();
    send_frame(10, 50);
    chk("mrst_next_fv", frame_valid, 1'b1);
    rd_chk("m10_rd5", 5, vec(10, 5));

    // Release in the completion cycle with the other bank full
    for (int i = 0; i < 49; i++) send_beat(vec(11, i), 1'b0, i);
    rel = 1'b1; rd_en = 1'b1; rd_addr = 6'd3;
    send_beat(vec(11, 49), 1'b1, 49);
    rel = 1'b0; rd_en = 1'b0;
    chk("col_rd_old_v", rd_valid, 1'b1);
    chk("col_rd_old", rd_data, vec(10, 3));
    chk("col_fv", frame_valid, 1'b1);
    chk("col_ovf", 104'(ovf_cnt), 0);
    rd_chk("col_rd_new", 3, vec(11, 3));
    release_bank();
    chk("col_final_fv", frame_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
